// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: RV32I opcode/funct constants,
// the extra-unit funct3 codes (also used by alu_extra) and the queue entry.
package alu_issue_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // funct3 codes executed by alu_extra when funct7 is FUNCT7_ALT.
  localparam logic [2:0] SUB = 3'h0;
  localparam logic [2:0] SRA = 3'h5;

  // OP-IMM funct3 codes whose op2 is a 5-bit shift amount.
  localparam logic [2:0] FUNCT3_SLL = 3'h1;
  localparam logic [2:0] FUNCT3_SRL = 3'h5;

  typedef enum logic {
    UnitBase  = 1'b0,
    UnitExtra = 1'b1
  } unit_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    unit_e       unit;
    logic [4:0]  rd;
  } entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder for RV32I OP / OP-IMM instructions.
// Ports:
//   instr_i    - raw instruction word
//   rs1_i      - source register 1 value (always op1)
//   rs2_i      - source register 2 value (op2 for OP)
//   entry_o    - decoded queue entry (funct3, op1, op2, unit, rd)
//   illegal_o  - instruction cannot be issued to either ALU unit
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output entry_t      entry_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] shamt;
  logic [31:0] imm_i;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign shamt  = {27'd0, instr_i[24:20]};
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};

  // The rs1 index is resolved upstream; only its data reaches this stage.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr_i[19:15];

  always_comb begin
    entry_o.funct3 = funct3;
    entry_o.op1    = rs1_i;
    entry_o.op2    = rs2_i;
    entry_o.unit   = UnitBase;
    entry_o.rd     = instr_i[11:7];
    illegal_o      = 1'b1;

    case (opcode)
      OPCODE_OP: begin
        if (funct7 == FUNCT7_BASE) begin
          illegal_o = 1'b0;
        end else if (funct7 == FUNCT7_ALT && (funct3 == SUB || funct3 == SRA)) begin
          illegal_o    = 1'b0;
          entry_o.unit = UnitExtra;
        end
      end
      OPCODE_OP_IMM: begin
        case (funct3)
          FUNCT3_SLL: begin
            entry_o.op2 = shamt;
            illegal_o   = (funct7 != FUNCT7_BASE);
          end
          FUNCT3_SRL: begin
            entry_o.op2 = shamt;
            if (funct7 == FUNCT7_BASE) begin
              illegal_o = 1'b0;
            end else if (funct7 == FUNCT7_ALT) begin
              illegal_o    = 1'b0;
              entry_o.unit = UnitExtra;
            end
          end
          default: begin
            entry_o.op2 = imm_i;
            illegal_o   = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage feeding the base ALU and alu_extra. Decodes OP/OP-IMM on
// acceptance, buffers decoded ops in a 2-entry queue, issues the head with
// exactly one unit enable, and delays (pop, rd) by one cycle so the tag lines
// up with the ALU's registered result.
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   in_valid / in_ready     - upstream handshake (in_ready = count < 2)
//   instruction, rs1_data, rs2_data - instruction and operands
//   out_ready               - downstream can take an op (registered upstream)
//   funct3, register_data_1/2 - head op (0 when the queue is empty)
//   enable_base/enable_extra  - one-hot issue strobes
//   wb_valid, wb_rd           - writeback tag aligned with ALU result
//   illegal_valid, illegal_instr - dropped-instruction report
module alu_issue
  import alu_issue_pkg::*;
#(
  // Only 2 is supported; the pointer logic below assumes a 1-bit index.
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        out_ready,
  output logic [2:0]  funct3,
  output logic [31:0] register_data_1,
  output logic [31:0] register_data_2,
  output logic        enable_base,
  output logic        enable_extra,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        illegal_valid,
  output logic [31:0] illegal_instr
);

  localparam logic [1:0] Full = 2'(DEPTH);

  entry_t      mem_q [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        illegal_valid_q, illegal_valid_d;
  logic [31:0] illegal_instr_q, illegal_instr_d;

  entry_t dec_entry;
  logic   dec_illegal;
  entry_t head;
  logic   accept, push, pop, not_empty, wr_idx;

  alu_issue_decode u_decode (
    .instr_i   (instruction),
    .rs1_i     (rs1_data),
    .rs2_i     (rs2_data),
    .entry_o   (dec_entry),
    .illegal_o (dec_illegal)
  );

  assign in_ready  = (count_q < Full);
  assign not_empty = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  // Illegal words consume the handshake but never occupy a slot.
  assign push      = accept & ~dec_illegal;
  assign pop       = not_empty & out_ready;
  assign head      = mem_q[head_q];
  // Tail slot is head + count (mod 2); count 2 never pushes.
  assign wr_idx    = head_q ^ count_q[0];

  always_comb begin
    head_d          = pop ? ~head_q : head_q;
    count_d         = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    wb_valid_d      = pop;
    wb_rd_d         = pop ? head.rd : 5'd0;
    illegal_valid_d = accept & dec_illegal;
    illegal_instr_d = (accept && dec_illegal) ? instruction : illegal_instr_q;
  end

  always_comb begin
    funct3          = not_empty ? head.funct3 : 3'd0;
    register_data_1 = not_empty ? head.op1 : 32'd0;
    register_data_2 = not_empty ? head.op2 : 32'd0;
    enable_base     = pop & (head.unit == UnitBase);
    enable_extra    = pop & (head.unit == UnitExtra);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q          <= 1'b0;
      count_q         <= 2'd0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      illegal_valid_q <= 1'b0;
      illegal_instr_q <= 32'd0;
    end else begin
      head_q          <= head_d;
      count_q         <= count_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      illegal_valid_q <= illegal_valid_d;
      illegal_instr_q <= illegal_instr_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_idx] <= dec_entry;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign illegal_valid = illegal_valid_q;
  assign illegal_instr = illegal_instr_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage directly upstream of the ALU units (base ALU and `alu_extra`). It accepts RV32I OP and OP-IMM instructions with their source operands over a valid/ready handshake. It decodes and buffers them in a 2-entry queue, then drives `funct3`, both operands and exactly one unit enable per issued operation. It also tracks the ALU's one-cycle registered latency and emits the destination register tag aligned with the ALU result for writeback.

## Interface
- `DEPTH`, 2: queue entries; the only supported value is 2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: instruction and operands are presented.
- `in_ready` output 1: stage can accept; equals (count < 2).
- `instruction` input 32: raw RV32I instruction word.
- `rs1_data` input 32: source register 1 value.
- `rs2_data` input 32: source register 2 value.
- `out_ready` input 1: downstream may take an op this cycle; must come from a register in the hazard unit.
- `funct3` output 3: operation select for the ALU units.
- `register_data_1` output 32: operand 1.
- `register_data_2` output 32: operand 2 (rs2, immediate, or shift amount).
- `enable_base` output 1: issue to the base ALU.
- `enable_extra` output 1: issue to `alu_extra` (SUB, SRA, SRAI).
- `wb_valid` output 1: ALU result valid this cycle.
- `wb_rd` output 5: destination register for that result.
- `illegal_valid` output 1: one-cycle pulse when an undecodable instruction is dropped.
- `illegal_instr` output 32: the most recent dropped instruction word.

## Operation
- Handshake: an instruction is accepted on a rising edge where `in_valid` and `in_ready` are both high. `instruction` and the operand inputs are ignored at any other time.
- Decode is applied at acceptance, and the decoded entry is written to the queue. Each entry holds `funct3`, op1, op2, a unit bit and `rd`.
- OP (opcode 0110011):
  - funct7 0000000: base unit, op2 = rs2.
  - funct7 0100000 with funct3 000 or 101: extra unit, op2 = rs2.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (opcode 0010011):
  - funct3 001: requires funct7 0000000; op2 = zero-extended `instruction[24:20]`.
  - funct3 101: funct7 0000000 issues SRLI to the base unit; 0100000 issues SRAI to the extra unit. Both use op2 = zero-extended `instruction[24:20]`. Any other funct7 is illegal.
  - Any other funct3: base unit, op2 = sign-extended `instruction[31:20]`.
- op1 is always `rs1_data`. `rd` is `instruction[11:7]`.
- Any other opcode is illegal.
- Illegal instruction handling:
  - The instruction is still accepted and consumes the handshake, but it is not enqueued.
  - `illegal_valid` pulses on the next cycle, and `illegal_instr` captures the word.
- Queue: 2 entries, head pointer, count in the range 0..2.
  - Pop occurs when count > 0 and `out_ready` is high.
  - Push and pop in the same cycle leave count unchanged.
  - A push is blocked at count 2 because `in_ready` is low.
- Output datapath: when count > 0, `funct3`, `register_data_1` and `register_data_2` show the head entry; they are 0 when the queue is empty.
- Unit enables: `enable_base` = pop AND head unit is base; `enable_extra` = pop AND head unit is extra. The two enables are never high together.
- Writeback: `wb_valid` and `wb_rd` are registered from (pop, head `rd`).

## Timing
- Reset values while `reset_n` is low:
  - count = 0 and `in_ready` = 1; inputs are not sampled.
  - `enable_base`, `enable_extra`, `wb_valid` and `illegal_valid` are 0.
  - `funct3`, both operands, `wb_rd` and `illegal_instr` are 0.
- Latency from acceptance at edge E with an empty queue and `out_ready` high:
  - The enable and operands are visible in the cycle after E.
  - The ALU captures at edge E+1.
  - `wb_valid` is high in the cycle after E+1, aligned with the ALU result.
- Throughput is one op per cycle with `out_ready` held high.
- Stall: with `out_ready` low, the head holds, both enables stay 0, and up to 2 entries accumulate before `in_ready` drops.
- Reset asserted mid-operation empties the queue and drops any in-flight `wb_valid` asynchronously. No partial writeback appears after reset is released.

## Structure
- Shared package `alu_issue_pkg`:
  - Constants OPCODE_OP = 7'b0110011 and OPCODE_OP_IMM = 7'b0010011.
  - FUNCT7_BASE = 7'h00 and FUNCT7_ALT = 7'h20.
  - Extra-unit funct3 values SUB = 3'h0 and SRA = 3'h5, shared with `alu_extra`.
  - Queue entry struct.
- Sub-module `alu_issue_decode`: combinational decoder from (instruction, rs1_data, rs2_data) to (entry, illegal).
- The queue and writeback registers live in `alu_issue`.

## Test plan
- `add x3,x1,x2` with rs1 = 5 and rs2 = 7, accepted with `out_ready` = 1:
  - Next cycle: `enable_base` = 1, `funct3` = 0, operands 5/7.
  - The cycle after: `wb_valid` = 1, `wb_rd` = 3.
- `sub x4` (funct7 0x20, funct3 0) and `srai x5,x1,4` (instruction 0x4040D293), issued back-to-back:
  - `enable_extra` = 1 for both ops on consecutive cycles.
  - op2 = rs2 for the sub, then op2 = 4 for the srai.
- `addi x6,x1,-1`: `enable_base` = 1, `register_data_2` = 0xFFFFFFFF.
- `out_ready` held 0 while 3 valid ops are offered:
  - Two ops are accepted, then `in_ready` = 0 and both enables stay 0.
  - After `out_ready` rises, the ops issue in order on 2 consecutive cycles and `in_ready` returns to 1.
- Instruction 0x0000006F (JAL):
  - It is accepted, with no enable and no `wb_valid`.
  - `illegal_valid` pulses once and `illegal_instr` = 0x0000006F.
- `reset_n` pulled low with 2 entries queued and one op in flight:
  - Immediately: all enables and valids are 0, `in_ready` = 1.
  - After release, no writeback is produced.
